conv_arbiter: RTL and testbench

- Shares one conv engine between two AXI-Stream requesters, each carrying pixel_pkg::chunk_t (3x3 RGB window).
- Round-robin burst arbitration on the request side.
- Records the requester ID of every chunk sent into the engine in an in-order tag FIFO.
- Steers each engine result back to the requester that issued it.
- Sits between the two window generators and the conv instance.

---
 rtl/conv_arbiter_if.sv | 16 +
 rtl/conv_arbiter.sv | 122 ++++++++++++
 tb/tb_conv_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_arbiter_if.sv
// Pixel window type shared by the window generators, the arbiter and the conv engine,
// plus the valid/ready stream interface that carries it.
package pixel_pkg;
  // 3x3 window of 24-bit RGB pixels
  typedef logic [8:0][23:0] chunk_t;
endpackage

interface axis_if;
  import pixel_pkg::*;
  chunk_t data;
  logic   vld;
  logic   rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/conv_arbiter.sv
// Round-robin burst arbiter sharing one conv engine between two requesters; an in-order
// tag FIFO remembers who issued each chunk so results can be steered back.
module conv_arbiter #(
  parameter int BURST_LEN = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  axis_if.slave                          req0_i,
  axis_if.slave                          req1_i,
  axis_if.master                         conv_o,
  axis_if.slave                          conv_i,
  axis_if.master                         rsp0_o,
  axis_if.master                         rsp1_o,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding_o,
  output logic                           err_o
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int OW = $clog2(TAG_DEPTH + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [OW-1:0] DEPTH      = OW'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t               state, state_nxt;
  logic                 last_grant;
  logic [BW-1:0]        burst_cnt;
  logic [TAG_DEPTH-1:0] tags;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [OW-1:0]        occ;
  logic                 fifo_full, fifo_empty, push, pop, head;

  assign fifo_full     = (occ == DEPTH);
  assign fifo_empty    = (occ == '0);
  assign head          = tags[rd_ptr];
  assign push          = conv_o.vld & conv_o.rdy;
  assign pop           = conv_i.vld & conv_i.rdy;
  assign outstanding_o = occ;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req0_i.vld && (!req1_i.vld || last_grant)) state_nxt = GNT0;
        else if (req1_i.vld)                           state_nxt = GNT1;
      end
      GNT0: if (!req0_i.vld || (push && burst_cnt == BURST_LAST)) state_nxt = IDLE;
      GNT1: if (!req1_i.vld || (push && burst_cnt == BURST_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through this block can infer a latch.
  always_comb begin
    conv_o.vld = 1'b0;
    req0_i.rdy = 1'b0;
    req1_i.rdy = 1'b0;
    case (state)
      GNT0: begin
        conv_o.vld = req0_i.vld & ~fifo_full;
        req0_i.rdy = conv_o.rdy & ~fifo_full;
      end
      GNT1: begin
        conv_o.vld = req1_i.vld & ~fifo_full;
        req1_i.rdy = conv_o.rdy & ~fifo_full;
      end
      default: ;
    endcase
    // last_grant only changes on entry to a grant, so the mux holds its source through IDLE
    conv_o.data = last_grant ? req1_i.data : req0_i.data;
    rsp0_o.data = conv_i.data;
    rsp1_o.data = conv_i.data;
    rsp0_o.vld  = conv_i.vld & ~fifo_empty & ~head;
    rsp1_o.vld  = conv_i.vld & ~fifo_empty &  head;
    conv_i.rdy  = ~fifo_empty & (head ? rsp1_o.rdy : rsp0_o.rdy);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else if (state == IDLE && state_nxt == GNT0) begin
      last_grant <= 1'b0;
      burst_cnt  <= '0;
    end else if (state == IDLE && state_nxt == GNT1) begin
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else if (push) begin
      burst_cnt  <= burst_cnt + 1'b1;
    end
  end

  // NOTE: tag storage needs no reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= last_grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
      if (conv_i.vld && fifo_empty) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_arbiter.sv
// Directed bench for conv_arbiter: requester drivers, a queue-based conv engine model and
// a scoreboard monitor that checks every routed result and the occupancy each cycle.
module tb_conv_arbiter;
  import pixel_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] outstanding;
  logic       err;

  axis_if req0_if();
  axis_if req1_if();
  axis_if cvo_if();
  axis_if cvi_if();
  axis_if rsp0_if();
  axis_if rsp1_if();

  conv_arbiter #(.BURST_LEN(16), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0_if), .req1_i(req1_if),
    .conv_o(cvo_if), .conv_i(cvi_if),
    .rsp0_o(rsp0_if), .rsp1_o(rsp1_if),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_left[2] = '{0, 0};
  int     seq[2]    = '{0, 0};
  int     sent[2]   = '{0, 0};
  int     delivered[2] = '{0, 0};
  int     rsp_seen[2]  = '{0, 0};
  int     occ_model = 0;
  bit     eng_en = 1'b0;
  bit     inject = 1'b0;
  chunk_t eng_q[$];
  chunk_t exp0[$];
  chunk_t exp1[$];
  int     deliver_log[$];
  int     trace[$];
  logic   h0, h1, ho, hi;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic chunk_t mk(input int r, input int s);
    chunk_t c;
    for (int i = 0; i < 9; i++) c[i] = {(r == 1) ? 8'hB1 : 8'hA0, 8'(i), 8'(s)};
    return c;
  endfunction

  // the engine model's transform, so a result can never be mistaken for a forwarded chunk
  function automatic chunk_t eng_fn(input chunk_t d);
    return d ^ {9{24'h5A3C96}};
  endfunction

  // drivers update just after the edge, after the main sequence has set its controls
  initial forever begin
    req0_if.vld = (n_left[0] > 0);
    req0_if.data = mk(0, seq[0]);
    req1_if.vld = (n_left[1] > 0);
    req1_if.data = mk(1, seq[1]);
    cvi_if.vld  = inject || (eng_en && eng_q.size() > 0);
    cvi_if.data = (eng_q.size() > 0) ? eng_q[0] : '0;
    @(posedge clk);
    #2;
  end

  // monitor / scoreboard, sampling mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      eng_q.delete();
      exp0.delete();
      exp1.delete();
      occ_model = 0;
    end else begin
      h0 = req0_if.vld & req0_if.rdy;
      h1 = req1_if.vld & req1_if.rdy;
      ho = cvo_if.vld & cvo_if.rdy;
      hi = cvi_if.vld & cvi_if.rdy;
      check("outstanding", outstanding, occ_model);
      if (ho) occ_model++;
      if (hi) occ_model--;
      if (rsp0_if.vld) rsp_seen[0]++;
      if (rsp1_if.vld) rsp_seen[1]++;
      if (rsp0_if.vld && rsp0_if.rdy) begin
        if (exp0.size() == 0) check("rsp0_unexpected", 1, 0);
        else                  check("rsp0_data", rsp0_if.data, exp0.pop_front());
        deliver_log.push_back(0);
        delivered[0]++;
      end
      if (rsp1_if.vld && rsp1_if.rdy) begin
        if (exp1.size() == 0) check("rsp1_unexpected", 1, 0);
        else                  check("rsp1_data", rsp1_if.data, exp1.pop_front());
        deliver_log.push_back(1);
        delivered[1]++;
      end
      if (hi) void'(eng_q.pop_front());
      if (ho) eng_q.push_back(eng_fn(cvo_if.data));
      if (h0) begin
        exp0.push_back(eng_fn(mk(0, seq[0])));
        seq[0]++; n_left[0]--; sent[0]++;
      end
      if (h1) begin
        exp1.push_back(eng_fn(mk(1, seq[1])));
        seq[1]++; n_left[1]--; sent[1]++;
      end
      trace.push_back(ho ? (h0 ? 0 : (h1 ? 1 : 2)) : -1);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    n_left = '{0, 0};
    eng_en = 1'b0;
    inject = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    seq = '{0, 0};
    sent = '{0, 0};
    delivered = '{0, 0};
    rsp_seen = '{0, 0};
    trace.delete();
    deliver_log.delete();
    rst = 1'b0;
  endtask

  task automatic wait_sent(input int r, input int n, input int budget);
    int i = 0;
    while (sent[r] < n && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("wait_sent", sent[r] >= n, 1);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (!(n_left[0] == 0 && n_left[1] == 0 && exp0.size() == 0 && exp1.size() == 0
             && occ_model == 0) && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain", i < budget, 1);
  endtask

  // splits the cycle trace into grant runs; every run must follow exactly one bubble
  task automatic check_bursts(input int es[$], input int el[$]);
    int rs[$], rl[$], rg[$];
    int gap = 0;
    foreach (trace[i]) begin
      if (trace[i] < 0) gap++;
      else if (rl.size() > 0 && gap == 0 && rs[rs.size()-1] == trace[i]) rl[rl.size()-1] += 1;
      else begin
        rs.push_back(trace[i]); rl.push_back(1); rg.push_back(gap); gap = 0;
      end
    end
    check("burst_count", rs.size(), es.size());
    for (int i = 0; i < es.size() && i < rs.size(); i++) begin
      check("burst_src", rs[i], es[i]);
      check("burst_len", rl[i], el[i]);
      check("burst_gap", rg[i], 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int es[$], el[$];
    int n_hs, first;
    rst = 1'b1;
    cvo_if.rdy = 1'b1;
    rsp0_if.rdy = 1'b1;
    rsp1_if.rdy = 1'b1;

    // reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err, 0);
    check("rst_conv_o_vld", cvo_if.vld, 0);
    check("rst_req0_rdy", req0_if.rdy, 0);
    check("rst_req1_rdy", req1_if.rdy, 0);
    check("rst_conv_i_rdy", cvi_if.rdy, 0);
    check("rst_rsp0_vld", rsp0_if.vld, 0);
    check("rst_rsp1_vld", rsp1_if.vld, 0);

    // single requester, 20 chunks: 16-beat burst then 4
    do_reset();
    eng_en = 1'b1;
    n_left[0] = 20;
    wait_drain(200);
    es = {0, 0}; el = {16, 4};
    check_bursts(es, el);
    check("t1_delivered0", delivered[0], 20);
    check("t1_rsp1_vld_seen", rsp_seen[1], 0);

    // both requesters valid: alternate 16-beat bursts starting with req0
    do_reset();
    eng_en = 1'b1;
    n_left = '{32, 32};
    wait_drain(300);
    es = {0, 1, 0, 1}; el = {16, 16, 16, 16};
    check_bursts(es, el);
    check("t2_delivered0", delivered[0], 32);
    check("t2_delivered1", delivered[1], 32);

    // engine stalled: exactly TAG_DEPTH chunks accepted, then back-pressure
    do_reset();
    n_left[0] = 12;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_hs = 0;
    foreach (trace[i]) if (trace[i] >= 0) n_hs++;
    check("t3_accepted", n_hs, 8);
    check("t3_conv_o_vld", cvo_if.vld, 0);
    check("t3_req0_rdy", req0_if.rdy, 0);
    check("t3_outstanding", outstanding, 8);
    @(posedge clk);
    #1;
    eng_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_outstanding_dec", outstanding, 7);
    @(posedge clk);
    #1;
    wait_drain(200);
    check("t3_delivered0", delivered[0], 12);

    // head-of-line blocking: head tag 1 stalled, tag 0 behind it
    do_reset();
    rsp1_if.rdy = 1'b0;
    n_left[1] = 1;
    wait_sent(1, 1, 20);
    n_left[0] = 1;
    wait_sent(0, 1, 20);
    repeat (2) @(posedge clk);
    #1;
    check("t4_outstanding", outstanding, 2);
    eng_en = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_conv_i_vld", cvi_if.vld, 1);
    check("t4_conv_i_rdy", cvi_if.rdy, 0);
    check("t4_rsp0_vld", rsp0_if.vld, 0);
    check("t4_nothing_delivered", deliver_log.size(), 0);
    @(posedge clk);
    #1;
    rsp1_if.rdy = 1'b1;
    wait_drain(50);
    check("t4_log_size", deliver_log.size(), 2);
    if (deliver_log.size() == 2) begin
      check("t4_first", deliver_log[0], 1);
      check("t4_second", deliver_log[1], 0);
    end

    // result with empty FIFO: refused and sticky error
    do_reset();
    inject = 1'b1;
    @(negedge clk);
    check("t5_conv_i_rdy", cvi_if.rdy, 0);
    check("t5_err_same_cycle", err, 0);
    @(negedge clk);
    check("t5_err_next", err, 1);
    @(posedge clk);
    #1;
    inject = 1'b0;
    eng_en = 1'b1;
    n_left[0] = 3;
    wait_drain(50);
    check("t5_delivered0", delivered[0], 3);
    check("t5_err_sticky", err, 1);
    do_reset();
    @(negedge clk);
    check("t5_err_cleared", err, 0);

    // asynchronous reset mid-burst in GNT1
    @(posedge clk);
    #1;
    n_left[1] = 10;
    wait_sent(1, 5, 30);
    #2;
    check("t6_pre_outstanding", outstanding, 5);
    check("t6_pre_req1_rdy", req1_if.rdy, 1);
    rst = 1'b1;
    n_left = '{0, 0};
    #1;
    check("t6_outstanding", outstanding, 0);
    check("t6_conv_o_vld", cvo_if.vld, 0);
    check("t6_req1_rdy", req1_if.rdy, 0);
    check("t6_conv_i_rdy", cvi_if.rdy, 0);
    check("t6_err", err, 0);
    do_reset();
    eng_en = 1'b1;
    n_left = '{2, 2};
    wait_drain(100);
    first = -1;
    foreach (trace[i]) if (first < 0 && trace[i] >= 0) first = trace[i];
    check("t6_first_grant", first, 0);
    check("t6_delivered0", delivered[0], 2);
    check("t6_delivered1", delivered[1], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
